// File: rtl/mm_result_drain_if.sv
// Result stream from the matrix-multiplier drain: one 8-bit C element per
// valid/ready transfer, tagged with its row-major index and the overflow snapshot.
interface mm_result_drain_if;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [3:0] out_idx;
  logic       out_last;
  logic       out_ovf;

  modport master (
    output out_valid,
    output out_data,
    output out_idx,
    output out_last,
    output out_ovf,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_idx,
    input  out_last,
    input  out_ovf,
    output out_ready
  );
endinterface

// File: rtl/mm_result_drain.sv
// Waits a settle interval after arm, snapshots the 3x3 C matrix and overflow flag,
// then streams the nine results row-major over a valid/ready handshake.
module mm_result_drain #(
  parameter int SETTLE_CYCLES = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               arm,
  input  logic [71:0]        c_in,
  input  logic               ovf_in,
  mm_result_drain_if.master  res,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_SEND
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(SETTLE_CYCLES - 1);
  localparam logic [3:0] LAST_IDX = 4'd8;

  state_t      state;
  logic [7:0]  settle_cnt;
  logic [71:0] snap;
  logic        snap_ovf;
  logic [3:0]  idx;
  logic        valid;

  // The snapshot is loaded only on the final settle edge, so the array may keep
  // changing during the burst without disturbing what is streamed out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      settle_cnt <= 8'd0;
      snap       <= 72'd0;
      snap_ovf   <= 1'b0;
      idx        <= 4'd0;
      valid      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (arm) begin
            state      <= ST_WAIT;
            settle_cnt <= 8'd0;
            busy       <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (settle_cnt == LAST_CNT) begin
            state      <= ST_SEND;
            settle_cnt <= 8'd0;
            snap       <= c_in;
            snap_ovf   <= ovf_in;
            idx        <= 4'd0;
            valid      <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt + 8'd1;
          end
        end
        ST_SEND: begin
          if (valid && res.out_ready) begin
            if (idx == LAST_IDX) begin
              state <= ST_IDLE;
              valid <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          valid <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Output word is a pure register-driven mux, so valid never depends on ready.
  always_comb begin
    res.out_valid = valid;
    res.out_idx   = idx;
    res.out_data  = snap[{idx, 3'b000} +: 8];
    res.out_last  = valid && (idx == LAST_IDX);
    res.out_ovf   = snap_ovf;
  end

endmodule

// File: tb/tb_mm_result_drain.sv
// Scoreboard bench for mm_result_drain: expected words are queued when a burst is
// armed and a negedge monitor pops and compares them as transfers happen.
module tb_mm_result_drain;

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] idx;
    logic       last;
    logic       ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        arm0 = 1'b0;
  logic        ovf0 = 1'b0;
  logic [71:0] c0 = '0;
  logic        busy0, done0;
  logic        arm1 = 1'b0;
  logic        ovf1 = 1'b0;
  logic [71:0] c1 = '0;
  logic        busy1, done1;

  exp_t q0[$];
  exp_t q1[$];
  int checks = 0;
  int errors = 0;
  int xfer0 = 0;
  int done_cnt0 = 0;
  int done_cnt1 = 0;

  always #5 clk = ~clk;

  mm_result_drain_if if0 ();
  mm_result_drain_if if1 ();

  mm_result_drain #(.SETTLE_CYCLES(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .arm(arm0), .c_in(c0), .ovf_in(ovf0),
    .res(if0), .busy(busy0), .done(done0)
  );

  mm_result_drain #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .arm(arm1), .c_in(c1), .ovf_in(ovf1),
    .res(if1), .busy(busy1), .done(done1)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [71:0] mk(input logic [7:0] base);
    logic [71:0] r;
    r = '0;
    for (int k = 0; k < 9; k++) r[8*k +: 8] = base + 8'(k);
    return r;
  endfunction

  task automatic pushExpected(input int which, input logic [71:0] c, input logic ovf);
    exp_t e;
    for (int k = 0; k < 9; k++) begin
      e.data = c[8*k +: 8];
      e.idx  = 4'(k);
      e.last = (k == 8);
      e.ovf  = ovf;
      if (which == 0) q0.push_back(e);
      else q1.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after an edge; the next edge is the arm edge E0.
  task automatic applyStimulus(input logic [71:0] c, input logic ovf);
    c0   = c;
    ovf0 = ovf;
    pushExpected(0, c, ovf);
    arm0 = 1'b1;
    tick();
    arm0 = 1'b0;
    checkOutput("busy_after_arm", 32'(busy0), 1);
  endtask

  task automatic waitValid(input int arm_at);
    for (int i = 1; i < 8; i++) begin
      if (i == arm_at) arm0 = 1'b1;
      tick();
      arm0 = 1'b0;
      checkOutput("valid_low_in_wait", 32'(if0.out_valid), 0);
    end
    tick();
    checkOutput("valid_rise", 32'(if0.out_valid), 1);
    checkOutput("first_idx", 32'(if0.out_idx), 0);
  endtask

  task automatic waitDone(input int budget, input logic [5:0] pat);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      if0.out_ready = pat[i % 6];
      tick();
      if (done0) found = 1'b1;
    end
    if0.out_ready = 1'b1;
    if (!found) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout: got no done within %0d cycles", budget);
    end else begin
      checkOutput("busy_low_with_done", 32'(busy0), 0);
    end
  endtask

  // Monitor for the default-settle instance: scoreboard, stall stability, done timing.
  initial begin
    bit         stall;
    bit         exp_done;
    logic [7:0] hd;
    logic [3:0] hi;
    logic       hl, ho;
    exp_t       e;
    stall = 0;
    exp_done = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall    = 0;
        exp_done = 0;
      end else begin
        if (exp_done) checkOutput("done_after_last", 32'(done0), 1);
        else if (done0) checkOutput("done_unexpected", 32'(done0), 0);
        if (done0) done_cnt0++;
        if (stall) begin
          checkOutput("stall_valid", 32'(if0.out_valid), 1);
          checkOutput("stall_data", 32'(if0.out_data), 32'(hd));
          checkOutput("stall_idx", 32'(if0.out_idx), 32'(hi));
          checkOutput("stall_last", 32'(if0.out_last), 32'(hl));
          checkOutput("stall_ovf", 32'(if0.out_ovf), 32'(ho));
        end
        if (if0.out_valid && if0.out_ready) begin
          xfer0++;
          if (q0.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL extra_word: got idx %0d data %0h, expected no word", if0.out_idx, if0.out_data);
          end else begin
            e = q0.pop_front();
            checkOutput("word_data", 32'(if0.out_data), 32'(e.data));
            checkOutput("word_idx", 32'(if0.out_idx), 32'(e.idx));
            checkOutput("word_last", 32'(if0.out_last), 32'(e.last));
            checkOutput("word_ovf", 32'(if0.out_ovf), 32'(e.ovf));
          end
        end
        exp_done = if0.out_valid && if0.out_ready && if0.out_last;
        stall    = if0.out_valid && !if0.out_ready;
        hd = if0.out_data;
        hi = if0.out_idx;
        hl = if0.out_last;
        ho = if0.out_ovf;
      end
    end
  end

  // Monitor for the single-cycle-settle instance.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (done1) done_cnt1++;
        if (if1.out_valid && if1.out_ready) begin
          if (q1.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL extra_word_corner: got idx %0d data %0h, expected no word", if1.out_idx, if1.out_data);
          end else begin
            e = q1.pop_front();
            checkOutput("corner_data", 32'(if1.out_data), 32'(e.data));
            checkOutput("corner_idx", 32'(if1.out_idx), 32'(e.idx));
            checkOutput("corner_last", 32'(if1.out_last), 32'(e.last));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int xb;
    int db;
    if0.out_ready = 1'b0;
    if1.out_ready = 1'b0;

    // Reset values
    #2;
    checkOutput("rst_valid", 32'(if0.out_valid), 0);
    checkOutput("rst_data", 32'(if0.out_data), 0);
    checkOutput("rst_idx", 32'(if0.out_idx), 0);
    checkOutput("rst_last", 32'(if0.out_last), 0);
    checkOutput("rst_ovf", 32'(if0.out_ovf), 0);
    checkOutput("rst_busy", 32'(busy0), 0);
    checkOutput("rst_done", 32'(done0), 0);
    checkOutput("rst_busy_corner", 32'(busy1), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Full-throughput burst
    $display("[TB] full-throughput burst");
    if0.out_ready = 1'b1;
    xb = xfer0;
    db = done_cnt0;
    applyStimulus(mk(8'h10), 1'b0);
    waitValid(0);
    checkOutput("first_data", 32'(if0.out_data), 'h10);
    repeat (9) tick();
    checkOutput("done_after_9", 32'(done0), 1);
    checkOutput("busy_with_done", 32'(busy0), 0);
    checkOutput("valid_with_done", 32'(if0.out_valid), 0);
    tick();
    checkOutput("done_one_cycle", 32'(done0), 0);
    checkOutput("xfers_full", 32'(xfer0 - xb), 9);
    checkOutput("done_count_full", 32'(done_cnt0 - db), 1);
    checkOutput("queue_empty_full", 32'(q0.size()), 0);

    // Backpressure
    $display("[TB] backpressure");
    xb = xfer0;
    db = done_cnt0;
    applyStimulus(mk(8'h10), 1'b0);
    waitValid(0);
    waitDone(80, 6'b101001);
    tick();
    checkOutput("xfers_bp", 32'(xfer0 - xb), 9);
    checkOutput("done_count_bp", 32'(done_cnt0 - db), 1);
    checkOutput("queue_empty_bp", 32'(q0.size()), 0);

    // Snapshot isolation and overflow
    $display("[TB] snapshot isolation");
    applyStimulus(mk(8'h40), 1'b1);
    waitValid(0);
    c0   = '1;
    ovf0 = 1'b0;
    if0.out_ready = 1'b0;
    tick();
    tick();
    waitDone(40, 6'b111111);
    tick();
    checkOutput("queue_empty_snap", 32'(q0.size()), 0);

    // Arm ignored while busy, accepted in the done cycle
    $display("[TB] arm while busy");
    db = done_cnt0;
    if0.out_ready = 1'b1;
    applyStimulus(mk(8'h60), 1'b0);
    waitValid(3);
    if0.out_ready = 1'b0;
    arm0 = 1'b1;
    tick();
    arm0 = 1'b0;
    if0.out_ready = 1'b1;
    repeat (9) tick();
    checkOutput("done_cycle", 32'(done0), 1);
    applyStimulus(mk(8'h70), 1'b0);
    waitValid(0);
    checkOutput("second_burst_data", 32'(if0.out_data), 'h70);
    waitDone(40, 6'b111111);
    tick();
    checkOutput("done_count_arm", 32'(done_cnt0 - db), 2);
    checkOutput("queue_empty_arm", 32'(q0.size()), 0);

    // Reset mid-burst
    $display("[TB] reset mid-burst");
    applyStimulus(mk(8'h80), 1'b1);
    waitValid(0);
    repeat (5) tick();
    checkOutput("idx_before_reset", 32'(if0.out_idx), 5);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 32'(if0.out_valid), 0);
    checkOutput("mid_rst_data", 32'(if0.out_data), 0);
    checkOutput("mid_rst_idx", 32'(if0.out_idx), 0);
    checkOutput("mid_rst_last", 32'(if0.out_last), 0);
    checkOutput("mid_rst_ovf", 32'(if0.out_ovf), 0);
    checkOutput("mid_rst_busy", 32'(busy0), 0);
    checkOutput("mid_rst_done", 32'(done0), 0);
    checkOutput("words_abandoned", 32'(q0.size()), 4);
    q0.delete();
    db = done_cnt0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("no_done_after_reset", 32'(done_cnt0 - db), 0);
    applyStimulus(mk(8'h90), 1'b0);
    waitValid(0);
    checkOutput("fresh_data", 32'(if0.out_data), 'h90);
    waitDone(40, 6'b111111);
    tick();
    checkOutput("done_count_fresh", 32'(done_cnt0 - db), 1);
    checkOutput("queue_empty_fresh", 32'(q0.size()), 0);

    // Single-cycle settle
    $display("[TB] settle of one cycle");
    if1.out_ready = 1'b1;
    c1   = mk(8'hA0);
    arm1 = 1'b1;
    tick();
    arm1 = 1'b0;
    checkOutput("corner_busy", 32'(busy1), 1);
    checkOutput("corner_valid_low", 32'(if1.out_valid), 0);
    c1 = mk(8'hB0);
    pushExpected(1, mk(8'hB0), 1'b0);
    tick();
    c1 = mk(8'hC0);
    checkOutput("corner_valid_rise", 32'(if1.out_valid), 1);
    checkOutput("corner_first_data", 32'(if1.out_data), 'hB0);
    begin
      bit found;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
        tick();
        if (done1) found = 1'b1;
      end
      if (!found) begin
        checks++;
        errors++;
        $display("[TB] FAIL corner_done_timeout: got no done within 20 cycles");
      end
    end
    tick();
    checkOutput("corner_done_count", 32'(done_cnt1), 1);
    checkOutput("corner_queue_empty", 32'(q1.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mm_result_drain.md
# mm_result_drain

Result-side drain for the 3x3 systolic floating-point matrix multiplier. After an `arm` pulse it waits a fixed settle interval for the array's C outputs and sticky overflow to become final, then snapshots all nine 8-bit results. It streams them out row-major as single words over a valid/ready handshake. It sits between the multiplier top and any downstream consumer (FIFO, bus bridge, checker).

## Interface
- `SETTLE_CYCLES`, default 8: clocks from the `arm` edge to the snapshot edge. Legal range is 1..255. Default covers the array's latest START_TIME (5) plus 2 accumulation steps plus 1 margin.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `arm`  in  1  start request, sampled on rising edge; ignored unless IDLE.
- `c_in`  in  72  flattened C matrix; element (i,j) at bits [8*(3*i+j)+7 : 8*(3*i+j)].
- `ovf_in`  in  1  overflow flag from the multiplier array.
- `out_valid`  out  1  word available.
- `out_ready`  in  1  consumer accepts word.
- `out_data`  out  8  current result word (8-bit float, passed through unmodified).
- `out_idx`  out  4  linear index 3*i+j of `out_data`, 0..8.
- `out_last`  out  1  high with index 8.
- `out_ovf`  out  1  snapshot of `ovf_in`, constant for the whole burst.
- `busy`  out  1  high in WAIT or SEND.
- `done`  out  1  one-cycle pulse after the last word transfers.

## Operation
- States:
  - IDLE: `busy`=0, `out_valid`=0.
  - WAIT: settle counter runs.
  - SEND: streams the snapshot.
- Transitions:
  - IDLE→WAIT on an edge with `arm`=1. Settle counter loads 0.
  - WAIT: counter increments each edge.
  - WAIT→SEND on the edge where the counter reaches SETTLE_CYCLES-1. On that same edge:
    - all 72 bits of `c_in` and `ovf_in` are registered into the snapshot;
    - `out_idx` is set to 0.
  - SEND: a transfer occurs on any edge with `out_valid`&&`out_ready`. The index increments after each transfer.
  - SEND→IDLE on the transfer of index 8. `done`=1 for the following cycle only.
- `out_data` = snapshot[8*out_idx +: 8]. `out_last` = (`out_idx`==8)&&`out_valid`.
- The snapshot is fixed during SEND; changes on `c_in`/`ovf_in` after capture do not affect the burst.
- `arm` in WAIT or SEND is ignored; there is no queueing and no restart.
- `arm` asserted in the cycle `done` is high is accepted, because the block is already in IDLE.
- No arithmetic on data. `out_idx` never exceeds 8 and never wraps.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `out_idx`=0, `out_last`=0, `out_ovf`=0, `busy`=0, `done`=0;
  - state IDLE, snapshot all zero, settle counter 0.
- Reset asserted mid-WAIT or mid-SEND:
  - outputs return to the reset values immediately (asynchronously);
  - the burst is abandoned and no `done` is issued.
- Latency:
  - arm edge E0 → snapshot and `out_valid`=1 after edge E0+SETTLE_CYCLES;
  - `busy` rises after E0;
  - with `out_ready` held high, 9 words take 9 consecutive cycles;
  - `done` is high in the cycle after the index-8 transfer edge, and `busy` is 0 in that same cycle.
- Handshake:
  - once `out_valid` rises, it stays high until the index-8 transfer;
  - `out_data`, `out_idx`, `out_last` and `out_ovf` are stable while `out_valid`&&!`out_ready`;
  - `out_ready` may toggle arbitrarily;
  - `out_valid` does not depend combinationally on `out_ready`.
- SETTLE_CYCLES=1: the snapshot is taken on the edge right after the arm edge.

## Test plan
- Full-throughput burst:
  - stimulus: reset, `c_in` element k = 8'h10+k, `ovf_in`=0, arm pulse, `out_ready`=1;
  - required: `out_valid` rises 8 cycles after the arm edge; words 8'h10..8'h18 arrive with idx 0..8 on consecutive cycles; `out_last` only on 8'h18; `done` pulses once; `busy` falls with `done`.
- Backpressure:
  - stimulus: same data, `out_ready` pattern 1,0,0,1,0,1…;
  - required: no word lost or repeated; data and idx held stable while stalled; exactly 9 transfers.
- Snapshot isolation and overflow:
  - stimulus: `ovf_in`=1 at capture; then change `c_in` to all 8'hFF and drop `ovf_in` during SEND;
  - required: the original values stream out; `out_ovf`=1 on all 9 words.
- Arm ignored while busy:
  - stimulus: extra arm pulses in WAIT and in SEND;
  - required: the capture cycle is unchanged; only one burst and one `done`. An arm in the `done` cycle starts a second burst SETTLE_CYCLES later.
- Reset mid-burst:
  - stimulus: assert `rst_n`=0 after idx 4 has transferred;
  - required: all outputs return to 0 immediately with no `done`. After release, an arm yields a fresh full burst starting at idx 0.
- Parameter corner:
  - stimulus: SETTLE_CYCLES=1;
  - required: `out_valid` rises 1 cycle after the arm edge and the snapshot equals `c_in` sampled at that edge.
